// File: rtl/score_board_pkg.sv
// Shared types and constants for the in-flight write scoreboard.
package score_board_pkg;

  localparam int ISSUE_WIDTH = 2;
  localparam int READ_PORTS  = 4;
  localparam int REG_NUM     = 32;
  localparam int NUM_STAGES  = 3;
  localparam int NUM_ENTRIES = NUM_STAGES * ISSUE_WIDTH;

  typedef logic [4:0] reg_addr_t;

  // Operand source; codes 1..6 equal (flat entry index + 1), entry index = stage*ISSUE_WIDTH + slot.
  typedef enum logic [2:0] {
    SRC_REGFILE = 3'd0,
    SRC_EX0     = 3'd1,
    SRC_EX1     = 3'd2,
    SRC_MEM0    = 3'd3,
    SRC_MEM1    = 3'd4,
    SRC_CMT0    = 3'd5,
    SRC_CMT1    = 3'd6
  } sb_src_e;

  typedef struct packed {
    logic    ready;
    sb_src_e src;
  } score_board_data_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t dst;
    logic      late;
  } sb_entry_t;

endpackage

// File: rtl/sb_lookup.sv
// Priority match of one operand register against all tracked entries.
module sb_lookup
  import score_board_pkg::*;
(
  input  reg_addr_t                    i_query_addr,
  input  sb_entry_t [NUM_ENTRIES-1:0]  i_entries,
  output score_board_data_t            o_data
);

  // Scan oldest stage first and lower slot first so the youngest match overwrites the result last.
  always_comb begin
    o_data.ready = 1'b1;
    o_data.src   = SRC_REGFILE;
    if (i_query_addr != '0) begin
      for (int st = NUM_STAGES - 1; st >= 0; st--) begin
        for (int sl = 0; sl < ISSUE_WIDTH; sl++) begin
          if (i_entries[st*ISSUE_WIDTH+sl].valid &&
              (i_entries[st*ISSUE_WIDTH+sl].dst == i_query_addr)) begin
            o_data.src   = sb_src_e'(3'(st*ISSUE_WIDTH + sl + 1));
            // A load still in EX has no result to forward yet.
            o_data.ready = !((st == 0) && i_entries[st*ISSUE_WIDTH+sl].late);
          end
        end
      end
    end
  end

endmodule

// File: rtl/score_board.sv
// Shadow of the EX/MEM/CMT destination registers; answers operand-source queries for issue/bypass.
module score_board
  import score_board_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic [ISSUE_WIDTH-1:0]            issue_valid,
  input  logic [ISSUE_WIDTH-1:0]            issue_wr_ena,
  input  logic [ISSUE_WIDTH-1:0][4:0]       issue_dst,
  input  logic [ISSUE_WIDTH-1:0]            issue_late,
  input  logic [READ_PORTS-1:0][4:0]        query_addr,
  output logic [READ_PORTS-1:0][3:0]        score_board_data,
  output logic [REG_NUM-1:0]                busy_mask
);

  sb_entry_t [ISSUE_WIDTH-1:0] r_ex;
  sb_entry_t [ISSUE_WIDTH-1:0] r_mem;
  sb_entry_t [ISSUE_WIDTH-1:0] r_cmt;

  sb_entry_t [NUM_ENTRIES-1:0]         w_entries;
  score_board_data_t [READ_PORTS-1:0]  w_data;
  logic [REG_NUM-1:0]                  w_busy;

  // Pipeline shadow: advance every cycle, flush clears, writes to r0 are never tracked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_cmt <= '0;
    end else if (flush) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_cmt <= '0;
    end else begin
      r_cmt <= r_mem;
      r_mem <= r_ex;
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
        r_ex[s].valid <= issue_valid[s] & issue_wr_ena[s] & (issue_dst[s] != 5'd0);
        r_ex[s].dst   <= issue_dst[s];
        r_ex[s].late  <= issue_late[s];
      end
    end
  end

  // Flat entry view: index = stage*ISSUE_WIDTH + slot (EX0, EX1, MEM0, MEM1, CMT0, CMT1).
  always_comb begin
    w_entries = {r_cmt, r_mem, r_ex};
  end

  // Busy mask: one bit per register written by any tracked entry.
  always_comb begin
    w_busy = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      if (w_entries[e].valid) w_busy[w_entries[e].dst] = 1'b1;
    end
  end

  assign busy_mask = w_busy;

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    sb_lookup u_lookup (
      .i_query_addr (query_addr[p]),
      .i_entries    (w_entries),
      .o_data       (w_data[p])
    );
    assign score_board_data[p] = w_data[p];
  end

endmodule

// File: tb/tb_score_board.sv
module tb_score_board;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [1:0]       issue_valid;
  logic [1:0]       issue_wr_ena;
  logic [1:0][4:0]  issue_dst;
  logic [1:0]       issue_late;
  logic [3:0][4:0]  query_addr;
  logic [3:0][3:0]  score_board_data;
  logic [31:0]      busy_mask;

  int n_cmp  = 0;
  int n_fail = 0;

  score_board dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .issue_valid      (issue_valid),
    .issue_wr_ena     (issue_wr_ena),
    .issue_dst        (issue_dst),
    .issue_late       (issue_late),
    .query_addr       (query_addr),
    .score_board_data (score_board_data),
    .busy_mask        (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: list of issued writes stamped with their issue cycle.
  // Age 1 = EX, 2 = MEM, 3 = CMT; gone after that.
  typedef struct {
    int         ic;
    int         slot;
    logic [4:0] dst;
    logic       late;
  } rec_t;
  rec_t recs[$];
  int   cyc = 0;

  function automatic logic [3:0] model_query(input logic [4:0] a);
    int best_age = 99;
    int best_slot = -1;
    logic best_late = 1'b0;
    if (a == 5'd0) return 4'h8;
    foreach (recs[i]) begin
      int age = cyc - recs[i].ic;
      if (age >= 1 && age <= 3 && recs[i].dst == a) begin
        if (age < best_age || (age == best_age && recs[i].slot > best_slot)) begin
          best_age  = age;
          best_slot = recs[i].slot;
          best_late = recs[i].late;
        end
      end
    end
    if (best_slot < 0) return 4'h8;
    return {~(best_age == 1 && best_late), 3'(1 + 2*(best_age-1) + best_slot)};
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] m = '0;
    foreach (recs[i]) begin
      int age = cyc - recs[i].ic;
      if (age >= 1 && age <= 3) m[recs[i].dst] = 1'b1;
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One rising edge; the model absorbs the inputs that were stable across it.
  task automatic tick();
    @(posedge clk);
    if (flush) recs.delete();
    else begin
      for (int s = 0; s < 2; s++)
        if (issue_valid[s] && issue_wr_ena[s] && issue_dst[s] != 5'd0)
          recs.push_back('{cyc, s, issue_dst[s], issue_late[s]});
    end
    cyc++;
    while (recs.size() > 0 && cyc - recs[0].ic > 3) void'(recs.pop_front());
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; issue_valid = '0; issue_wr_ena = '0; issue_dst = '0; issue_late = '0;
  endtask

  typedef struct {
    logic        fl;
    logic [1:0]  iv, we, lt;
    logic [4:0]  d0, d1;
    logic [4:0]  q0, q1, q2, q3;
    logic [3:0]  e0, e1, e2, e3;
    logic [31:0] busy;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic fl, input logic [1:0] iv, we, lt,
                              input logic [4:0] d0, d1, q0, q1, q2, q3,
                              input logic [3:0] e0, e1, e2, e3, input logic [31:0] busy);
    vec_t v;
    v.fl = fl; v.iv = iv; v.we = we; v.lt = lt; v.d0 = d0; v.d1 = d1;
    v.q0 = q0; v.q1 = q1; v.q2 = q2; v.q3 = q3;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3; v.busy = busy;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // {ready,src}: 8=REGFILE 9=EX0 A=EX1 B=MEM0 C=MEM1 D=CMT0 E=CMT1 2=EX1 not ready
    // ALU dst=5 on slot 0
    vecs.push_back(mk(0,2'b01,2'b01,2'b00, 5, 0, 5,0,7,3, 4'h9,4'h8,4'h8,4'h8, 32'h20));
    vecs.push_back(mk(0,2'b00,2'b00,2'b00, 0, 0, 5,0,7,3, 4'hB,4'h8,4'h8,4'h8, 32'h20));
    vecs.push_back(mk(0,2'b00,2'b00,2'b00, 0, 0, 5,0,7,3, 4'hD,4'h8,4'h8,4'h8, 32'h20));
    vecs.push_back(mk(0,2'b00,2'b00,2'b00, 0, 0, 5,0,7,3, 4'h8,4'h8,4'h8,4'h8, 32'h0));
    // load dst=7 on slot 1
    vecs.push_back(mk(0,2'b10,2'b10,2'b10, 0, 7, 7,5,0,3, 4'h2,4'h8,4'h8,4'h8, 32'h80));
    vecs.push_back(mk(0,2'b00,2'b00,2'b00, 0, 0, 7,5,0,3, 4'hC,4'h8,4'h8,4'h8, 32'h80));
    vecs.push_back(mk(0,2'b00,2'b00,2'b00, 0, 0, 7,5,0,3, 4'hE,4'h8,4'h8,4'h8, 32'h80));
    vecs.push_back(mk(0,2'b00,2'b00,2'b00, 0, 0, 7,5,0,3, 4'h8,4'h8,4'h8,4'h8, 32'h0));
    // dst=3 slot0, then dst=3 slot1: youngest wins
    vecs.push_back(mk(0,2'b01,2'b01,2'b00, 3, 0, 3,7,5,0, 4'h9,4'h8,4'h8,4'h8, 32'h8));
    vecs.push_back(mk(0,2'b10,2'b10,2'b00, 0, 3, 3,7,5,0, 4'hA,4'h8,4'h8,4'h8, 32'h8));
    vecs.push_back(mk(0,2'b00,2'b00,2'b00, 0, 0, 3,7,5,0, 4'hC,4'h8,4'h8,4'h8, 32'h8));
    vecs.push_back(mk(0,2'b00,2'b00,2'b00, 0, 0, 3,7,5,0, 4'hE,4'h8,4'h8,4'h8, 32'h8));
    vecs.push_back(mk(0,2'b00,2'b00,2'b00, 0, 0, 3,7,5,0, 4'h8,4'h8,4'h8,4'h8, 32'h0));
    // both slots dst=3 in the same cycle
    vecs.push_back(mk(0,2'b11,2'b11,2'b00, 3, 3, 3,3,0,1, 4'hA,4'hA,4'h8,4'h8, 32'h8));
    vecs.push_back(mk(0,2'b00,2'b00,2'b00, 0, 0, 3,3,0,1, 4'hC,4'hC,4'h8,4'h8, 32'h8));
    vecs.push_back(mk(0,2'b00,2'b00,2'b00, 0, 0, 3,3,0,1, 4'hE,4'hE,4'h8,4'h8, 32'h8));
    vecs.push_back(mk(0,2'b00,2'b00,2'b00, 0, 0, 3,3,0,1, 4'h8,4'h8,4'h8,4'h8, 32'h0));
    // dst=0 with wr_ena, dst=9 without wr_ena
    vecs.push_back(mk(0,2'b11,2'b01,2'b00, 0, 9, 0,9,0,9, 4'h8,4'h8,4'h8,4'h8, 32'h0));
    vecs.push_back(mk(0,2'b00,2'b00,2'b00, 0, 0, 0,9,0,9, 4'h8,4'h8,4'h8,4'h8, 32'h0));
    // r6 into MEM, r4 into EX, then flush with a new issue dst=8
    vecs.push_back(mk(0,2'b01,2'b01,2'b00, 6, 0, 4,6,8,0, 4'h8,4'h9,4'h8,4'h8, 32'h40));
    vecs.push_back(mk(0,2'b01,2'b01,2'b00, 4, 0, 4,6,8,0, 4'h9,4'hB,4'h8,4'h8, 32'h50));
    vecs.push_back(mk(1,2'b01,2'b01,2'b00, 8, 0, 4,6,8,0, 4'h8,4'h8,4'h8,4'h8, 32'h0));
    vecs.push_back(mk(0,2'b00,2'b00,2'b00, 0, 0, 4,6,8,0, 4'h8,4'h8,4'h8,4'h8, 32'h0));

    // Reset state
    idle_inputs();
    query_addr = '{5'd5, 5'd3, 5'd1, 5'd0};
    rst_n = 1'b0;
    #12;
    chk("reset_data_async", 32'(score_board_data), 32'h8888);
    chk("reset_busy_async", busy_mask, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_data", 32'(score_board_data), 32'h8888);
    chk("reset_busy", busy_mask, 32'h0);

    // Table-driven directed sequences
    foreach (vecs[i]) begin
      flush = vecs[i].fl; issue_valid = vecs[i].iv; issue_wr_ena = vecs[i].we;
      issue_late = vecs[i].lt; issue_dst[0] = vecs[i].d0; issue_dst[1] = vecs[i].d1;
      query_addr[0] = vecs[i].q0; query_addr[1] = vecs[i].q1;
      query_addr[2] = vecs[i].q2; query_addr[3] = vecs[i].q3;
      tick();
      chk($sformatf("vec%0d_p0", i), 32'(score_board_data[0]), 32'(vecs[i].e0));
      chk($sformatf("vec%0d_p1", i), 32'(score_board_data[1]), 32'(vecs[i].e1));
      chk($sformatf("vec%0d_p2", i), 32'(score_board_data[2]), 32'(vecs[i].e2));
      chk($sformatf("vec%0d_p3", i), 32'(score_board_data[3]), 32'(vecs[i].e3));
      chk($sformatf("vec%0d_busy", i), busy_mask, vecs[i].busy);
    end

    // Reset mid-flight with r5 in MEM
    idle_inputs();
    query_addr = '{5'd0, 5'd0, 5'd0, 5'd5};
    issue_valid = 2'b01; issue_wr_ena = 2'b01; issue_dst[0] = 5'd5;
    tick();
    idle_inputs();
    tick();
    chk("midrst_before", 32'(score_board_data[0]), 32'hB);
    rst_n = 1'b0;
    #1;
    recs.delete();
    chk("midrst_data", 32'(score_board_data[0]), 32'h8);
    chk("midrst_busy", busy_mask, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("midrst_after", 32'(score_board_data[0]), 32'h8);

    // Randomized stimulus against the reference model
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 15) == 0);
      for (int s = 0; s < 2; s++) begin
        issue_valid[s]  = $urandom_range(0, 3) != 0;
        issue_wr_ena[s] = $urandom_range(0, 3) != 0;
        issue_dst[s]    = 5'($urandom_range(0, 7));
        issue_late[s]   = $urandom_range(0, 1) == 1;
      end
      for (int p = 0; p < 4; p++) query_addr[p] = 5'($urandom_range(0, 8));
      tick();
      for (int p = 0; p < 4; p++)
        chk($sformatf("rand%0d_p%0d_q%0d", c, p, query_addr[p]),
            32'(score_board_data[p]), 32'(model_query(query_addr[p])));
      chk($sformatf("rand%0d_busy", c), busy_mask, model_busy());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
